// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the scoreboarded register file.
// Revision 1.0 - initial release
`default_nettype none

package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Low bit index of lane k inside a packed multi-port bus of lane width w
  function automatic int port_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with reserve-over-clear priority and a running busy count.
// Revision 1.0 - initial release
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_cnt;
  logic             w_set;
  logic             w_clr0;
  logic             w_clr1;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < DEPTH; r++) begin
      if (rsv_en && rsv_addr == ADDR_W'(r))
        w_busy_nxt[r] = 1'b1;
      else if ((wr0_en && wr0_addr == ADDR_W'(r)) || (wr1_en && wr1_addr == ADDR_W'(r)))
        w_busy_nxt[r] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Transition detection for the incremental count; a register cleared by both lanes counts once
  assign w_set  = rsv_en && (rsv_addr != c_zero_addr) && !r_busy[rsv_addr];
  assign w_clr0 = wr0_en && (wr0_addr != c_zero_addr) && r_busy[wr0_addr]
                  && !(rsv_en && rsv_addr == wr0_addr);
  assign w_clr1 = wr1_en && (wr1_addr != c_zero_addr) && r_busy[wr1_addr]
                  && !(rsv_en && rsv_addr == wr1_addr)
                  && !(w_clr0 && wr0_addr == wr1_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= r_cnt + (ADDR_W+1)'(w_set) - (ADDR_W+1)'(w_clr0) - (ADDR_W+1)'(w_clr1);
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read, dual-write register file with RAW scoreboard.
// Optional write-first read forwarding enabled by macro REGFILE_BYPASS_EN. Revision 1.0
`default_nettype none

module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt,
  input  logic [ADDR_W-1:0]        test_addr,
  output logic [DATA_W-1:0]        test_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .busy     (w_busy),
    .busy_cnt (busy_cnt)
  );

  // Lane 1 is the younger instruction, so its write is issued last and wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (wr0_en && wr0_addr != c_zero_addr)
        r_mem[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != c_zero_addr)
        r_mem[wr1_addr] <= wr1_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[port_lo(k, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic w_hit0;
    logic w_hit1;
    assign w_hit0 = wr0_en && (wr0_addr == w_addr) && (w_addr != c_zero_addr);
    assign w_hit1 = wr1_en && (wr1_addr == w_addr) && (w_addr != c_zero_addr);
    assign rd_data[port_lo(k, DATA_W) +: DATA_W] = w_hit1 ? wr1_data :
                                                   w_hit0 ? wr0_data : r_mem[w_addr];
    // A same-cycle reservation to the address means a new producer is still outstanding
    assign rd_busy[k] = ((w_hit0 || w_hit1) && !(rsv_en && rsv_addr == w_addr)) ? 1'b0
                                                                                : w_busy[w_addr];
`else
    assign rd_data[port_lo(k, DATA_W) +: DATA_W] = r_mem[w_addr];
    assign rd_busy[k] = w_busy[w_addr];
`endif
  end

  assign test_data = r_mem[test_addr];

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed self-checking bench for regfile_mp_sb (honours REGFILE_BYPASS_EN).
// Revision 1.0 - initial release
`default_nettype none

module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr0_en, wr1_en, rsv_en;
  logic [AW-1:0]    wr0_addr, wr1_addr, rsv_addr, test_addr;
  logic [DW-1:0]    wr0_data, wr1_data, test_data;
  logic [AW:0]      busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_cnt  (busy_cnt),
    .test_addr (test_addr),
    .test_data (test_data)
  );

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); rd_addr = {5'd3, 5'd0}; test_addr = 5'd3;
    #2;
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    n_checks++; if (rd_busy !== '0) begin n_fail++; $display("FAIL reset_rd_busy: got %b expected 0", rd_busy); end
    n_checks++; if (busy_cnt !== '0) begin n_fail++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt); end
    n_checks++; if (test_data !== '0) begin n_fail++; $display("FAIL reset_test_data: got %h expected 0", test_data); end
    tick(); rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd4;
    tick(); idle(); #1;
    n_checks++; if (test_data !== 32'h55) begin n_fail++; $display("FAIL pre_reset_write: got %h expected 00000055", test_data); end
    n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d expected 1", busy_cnt); end
    // Pending write and reservation are in flight when reset drops asynchronously
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h66; rsv_en = 1'b1; rsv_addr = 5'd5;
    #2 rst = 1'b0; #1;
    n_checks++; if (busy_cnt !== '0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d expected 0", busy_cnt); end
    n_checks++; if (test_data !== '0) begin n_fail++; $display("FAIL async_reset_data: got %h expected 0", test_data); end
    tick(); rst = 1'b1; idle(); rd_addr = {5'd5, 5'd4}; #1;
    n_checks++; if (test_data !== '0) begin n_fail++; $display("FAIL reset_discard_write: got %h expected 0", test_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_discard_rsv: got %b expected 00", rd_busy); end
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hDEADBEEF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0}; test_addr = 5'd0;
    #1;
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL r0_same_cycle: got %h expected 0", rd_data); end
    tick(); idle(); #1;
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL r0_read: got %h expected 0", rd_data); end
    n_checks++; if (test_data !== '0) begin n_fail++; $display("FAIL r0_test_data: got %h expected 0", test_data); end
    n_checks++; if (busy_cnt !== '0 || rd_busy !== '0) begin n_fail++; $display("FAIL r0_busy: got cnt %0d busy %b expected 0/00", busy_cnt, rd_busy); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp;
    rd_addr = {5'd0, 5'd9};
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h12345678;
    #1;
    exp = BP ? 32'h12345678 : 32'h0;
    n_checks++; if (rd_data[31:0] !== exp) begin n_fail++; $display("FAIL wr_same_cycle: got %h expected %h", rd_data[31:0], exp); end
    tick(); idle(); #1;
    n_checks++; if (rd_data[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL wr_next_cycle: got %h expected 12345678", rd_data[31:0]); end
  endtask

  task automatic test_dual_write();
    logic [DW-1:0] exp;
    rd_addr = {5'd10, 5'd9};
    wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h1;
    wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'h2;
    #1;
    exp = BP ? 32'h2 : 32'h0;
    n_checks++; if (rd_data[63:32] !== exp) begin n_fail++; $display("FAIL dual_same_cycle: got %h expected %h", rd_data[63:32], exp); end
    tick(); idle(); test_addr = 5'd10; #1;
    n_checks++; if (test_data !== 32'h2) begin n_fail++; $display("FAIL dual_test_data: got %h expected 00000002", test_data); end
    n_checks++; if (rd_data[63:32] !== 32'h2) begin n_fail++; $display("FAIL dual_rd_data: got %h expected 00000002", rd_data[63:32]); end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 5'd8; tick();
    rsv_addr = 5'd11; tick(); idle(); rd_addr = {5'd11, 5'd8}; #1;
    n_checks++; if (busy_cnt !== 6'd2) begin n_fail++; $display("FAIL sb_two_rsv_cnt: got %0d expected 2", busy_cnt); end
    n_checks++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL sb_two_rsv_busy: got %b expected 11", rd_busy); end
    rsv_en = 1'b1; rsv_addr = 5'd8; tick(); idle(); #1;
    n_checks++; if (busy_cnt !== 6'd2) begin n_fail++; $display("FAIL sb_rersv_cnt: got %0d expected 2", busy_cnt); end
    wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'h88; tick(); idle(); #1;
    n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_clear_cnt: got %0d expected 1", busy_cnt); end
    n_checks++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL sb_clear_busy: got %b expected 10", rd_busy); end
    n_checks++; if (rd_data[31:0] !== 32'h88) begin n_fail++; $display("FAIL sb_clear_data: got %h expected 00000088", rd_data[31:0]); end
    rsv_en = 1'b1; rsv_addr = 5'd11; wr0_en = 1'b1; wr0_addr = 5'd11; wr0_data = 32'hBB;
    tick(); idle(); test_addr = 5'd11; #1;
    n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_rsv_beats_wr_cnt: got %0d expected 1", busy_cnt); end
    n_checks++; if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL sb_rsv_beats_wr_busy: got %b expected 1", rd_busy[1]); end
    n_checks++; if (test_data !== 32'hBB) begin n_fail++; $display("FAIL sb_rsv_wr_data: got %h expected 000000bb", test_data); end
    // One set and one clear in the same edge leave the count unchanged
    rsv_en = 1'b1; rsv_addr = 5'd13; wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'hCC;
    tick(); idle(); rd_addr = {5'd13, 5'd11}; #1;
    n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_set_clear_cnt: got %0d expected 1", busy_cnt); end
    n_checks++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL sb_set_clear_busy: got %b expected 10", rd_busy); end
    wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'hDD; tick(); idle();
    wr0_en = 1'b1; wr0_addr = 5'd14; wr0_data = 32'hEE; tick(); idle(); rd_addr = {5'd14, 5'd13}; #1;
    n_checks++; if (busy_cnt !== '0) begin n_fail++; $display("FAIL sb_drain_cnt: got %0d expected 0", busy_cnt); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL sb_nonbusy_write: got %b expected 00", rd_busy); end
    n_checks++; if (rd_data[63:32] !== 32'hEE) begin n_fail++; $display("FAIL sb_nonbusy_data: got %h expected 000000ee", rd_data[63:32]); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_d;
    logic          exp_b;
    rsv_en = 1'b1; rsv_addr = 5'd12; tick(); idle();
    rd_addr = {5'd12, 5'd0};
    wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hA5A5A5A5;
    #1;
    exp_d = BP ? 32'hA5A5A5A5 : 32'h0;
    exp_b = BP ? 1'b0 : 1'b1;
    n_checks++; if (rd_data[63:32] !== exp_d) begin n_fail++; $display("FAIL bypass_data: got %h expected %h", rd_data[63:32], exp_d); end
    n_checks++; if (rd_busy[1] !== exp_b) begin n_fail++; $display("FAIL bypass_busy: got %b expected %b", rd_busy[1], exp_b); end
    tick(); idle(); #1;
    n_checks++; if (rd_data[63:32] !== 32'hA5A5A5A5 || rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL bypass_after: got %h/%b expected a5a5a5a5/0", rd_data[63:32], rd_busy[1]); end
    n_checks++; if (busy_cnt !== '0) begin n_fail++; $display("FAIL bypass_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_count_stress();
    int exp;
    for (int r = 1; r < 32; r++) begin
      rsv_en = 1'b1; rsv_addr = AW'(r); tick();
      n_checks++; if (busy_cnt !== (AW+1)'(r)) begin n_fail++; $display("FAIL stress_fill_%0d: got %0d expected %0d", r, busy_cnt, r); end
    end
    idle(); #1;
    n_checks++; if (busy_cnt !== 6'd31) begin n_fail++; $display("FAIL stress_full: got %0d expected 31", busy_cnt); end
    exp = 31;
    for (int i = 0; i < 16; i++) begin
      wr0_en = 1'b1; wr0_addr = AW'(2*i + 1); exp = exp - 1;
      if (2*i + 2 < 32) begin wr1_en = 1'b1; wr1_addr = AW'(2*i + 2); exp = exp - 1; end
      else begin wr1_en = 1'b0; wr1_addr = '0; end
      tick(); idle();
      n_checks++; if (busy_cnt !== (AW+1)'(exp)) begin n_fail++; $display("FAIL stress_drain_%0d: got %0d expected %0d", i, busy_cnt, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_bypass();
    test_count_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
